all_gates: RTL and testbench
============================

// Module: all_gates
// PURPOSE
// - Bitwise two-input logic unit: computes AND, OR, NAND, NOR, XOR and XNOR of operands a and b.
// - Combinational outputs are available in the same cycle. A registered, packed copy of all six results is held for downstream pipelines.
// - Used as a leaf utility block and as a gate-level sanity/teaching target in the datapath library.
// PARAMETERS
// - WIDTH  1  operand width in bits; every gate output is WIDTH bits wide.
// PORTS
// - clk      in   1          system clock, rising edge; the only clock.
// - rst_n    in   1          reset, asynchronous assert, active-low; clears all registers.
// - a        in   WIDTH      operand A.
// - b        in   WIDTH      operand B.
// - en       in   1          capture enable for the registered bus.
// - _and     out  WIDTH      a & b (combinational).
// - _or      out  WIDTH      a | b (combinational).
// - _nand    out  WIDTH      ~(a & b) (combinational).
// - _nor     out  WIDTH      ~(a | b) (combinational).
// - _xor     out  WIDTH      a ^ b (combinational).
// - _xnor    out  WIDTH      ~(a ^ b) (combinational).
// - gates_q  out  6*WIDTH    registered results, packed {xnor,xor,nor,nand,or,and}; and occupies the LSB slice.
// - valid_q  out  1          gates_q holds a capture taken since the last reset.
// BEHAVIOUR
// - The six gate outputs are purely combinational.
//   - Zero latency; they do not depend on clk, rst_n or en.
//   - They are valid even while rst_n is low.
// - Bit i of each output depends only on a[i] and b[i]; there is no cross-bit logic.
// - X or Z inputs propagate per standard Verilog operator semantics; no sanitising.
// - Reset (rst_n=0, asynchronous): gates_q = 0 and valid_q = 0 immediately, held while low.
// - Release of rst_n is synchronised only by the next rising clk edge.
// - Rising clk with en=1: gates_q <= the current combinational results and valid_q <= 1. Latency is 1 cycle.
// - Rising clk with en=0: gates_q and valid_q hold their values.
// - Reset asserted mid-capture (same edge): reset wins; registers read 0.
// - Invariants that must always hold: _nand == ~_and, _nor == ~_or, _xnor == ~_xor.
// CONFIGURATION
// - Macro ALL_GATES_REDUCE_EN, when defined, adds one output:
//   - reduce_q  out  6  registered per-gate OR-reduction (bit k = |gate_k result).
//   - Bit order matches the gates_q slice order.
//   - Captured under the same en rule; resets to 0.
// - When ALL_GATES_REDUCE_EN is not defined, the port and its logic are absent. All other behaviour is identical.
// STRUCTURE
// - Package all_gates_pkg holds:
//   - NUM_GATES = 6.
//   - Slice indices GATE_AND=0, GATE_OR=1, GATE_NAND=2, GATE_NOR=3, GATE_XOR=4, GATE_XNOR=5.
//   - A helper function that returns the bit offset of slice k (k*WIDTH).
// - Sub-module gate_slice: 1-bit a,b in; 6-bit gate vector out.
//   - Instantiated WIDTH times via generate.
//   - The top level fans the vector out to the named ports and to the gates_q packing.
// - Register stage and optional reduce logic live in the top level.
// TESTING
// - Truth table, WIDTH=1, 10 ns per step.
//   - a,b = 00/01/10/11.
//   - _and = 0,0,0,1.
//   - _or = 0,1,1,1.
//   - _nand = 1,1,1,0.
//   - _nor = 1,0,0,0.
//   - _xor = 0,1,1,0.
//   - _xnor = 1,0,0,1.
// - Reset: hold rst_n=0 with a=1,b=1.
//   - Required: gates_q=0 and valid_q=0.
//   - Required: _and=1 and _xnor=1 regardless of reset.
// - Capture: WIDTH=4, a=4'hC, b=4'hA, en=1 for one edge.
//   - Required: gates_q slices and=8, or=E, nand=7, nor=1, xor=6, xnor=9; valid_q=1.
// - Hold: change to a=0,b=F with en=0 for 3 edges.
//   - Required: gates_q is unchanged; combinational outputs update immediately.
// - Async reset mid-run: drop rst_n between clock edges.
//   - Required: gates_q and valid_q become 0 before the next edge.
// - Randomised invariant check, with ALL_GATES_REDUCE_EN defined and undefined.
//   - Required: complement invariants hold every step.
//   - Required when defined: reduce_q matches the per-slice OR-reduction of gates_q.

Source files
------------

// File: rtl/all_gates_pkg.sv
// Shared constants for the all_gates bitwise logic unit: gate slice indices and packing helper.
package all_gates_pkg;

  localparam int unsigned NUM_GATES = 6;

  localparam int unsigned GATE_AND  = 0;
  localparam int unsigned GATE_OR   = 1;
  localparam int unsigned GATE_NAND = 2;
  localparam int unsigned GATE_NOR  = 3;
  localparam int unsigned GATE_XOR  = 4;
  localparam int unsigned GATE_XNOR = 5;

  typedef logic [NUM_GATES-1:0] gate_vec_t;

  // Bit offset of gate slice k inside a packed {xnor,xor,nor,nand,or,and} bus.
  function automatic int unsigned slice_offset(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/all_gates_slice.sv
// One bit position of the logic unit: all six gate results for a single a/b bit pair.
module gate_slice
  import all_gates_pkg::*;
(
  input  logic      a_i,
  input  logic      b_i,
  output gate_vec_t gates_o
);

  logic and_b;
  logic or_b;
  logic xor_b;

  assign and_b = a_i & b_i;
  assign or_b  = a_i | b_i;
  assign xor_b = a_i ^ b_i;

  // Inverting gates are built from their positive twins so the complement pairs match by construction.
  always_comb begin
    gates_o            = '0;
    gates_o[GATE_AND]  = and_b;
    gates_o[GATE_OR]   = or_b;
    gates_o[GATE_NAND] = ~and_b;
    gates_o[GATE_NOR]  = ~or_b;
    gates_o[GATE_XOR]  = xor_b;
    gates_o[GATE_XNOR] = ~xor_b;
  end

endmodule

// File: rtl/all_gates.sv
// Bitwise two-input logic unit with combinational gate outputs and a registered packed copy.
// Optional macro ALL_GATES_REDUCE_EN adds reduce_q, a registered per-gate OR-reduction.
module all_gates
  import all_gates_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     en,
  output logic [WIDTH-1:0]         _and,
  output logic [WIDTH-1:0]         _or,
  output logic [WIDTH-1:0]         _nand,
  output logic [WIDTH-1:0]         _nor,
  output logic [WIDTH-1:0]         _xor,
  output logic [WIDTH-1:0]         _xnor,
  output logic [NUM_GATES*WIDTH-1:0] gates_q,
  output logic                     valid_q
`ifdef ALL_GATES_REDUCE_EN
  ,
  output logic [NUM_GATES-1:0]     reduce_q
`endif
);

  gate_vec_t                   slice_vec [WIDTH];
  logic [NUM_GATES*WIDTH-1:0]  gates_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    gate_slice u_gate_slice (
      .a_i     (a[i]),
      .b_i     (b[i]),
      .gates_o (slice_vec[i])
    );
  end

  // Transpose per-bit gate vectors into per-gate slices of the packed bus.
  for (genvar k = 0; k < NUM_GATES; k++) begin : g_pack_gate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pack_bit
      assign gates_d[slice_offset(k, WIDTH) + i] = slice_vec[i][k];
    end
  end

  assign _and  = gates_d[slice_offset(GATE_AND,  WIDTH) +: WIDTH];
  assign _or   = gates_d[slice_offset(GATE_OR,   WIDTH) +: WIDTH];
  assign _nand = gates_d[slice_offset(GATE_NAND, WIDTH) +: WIDTH];
  assign _nor  = gates_d[slice_offset(GATE_NOR,  WIDTH) +: WIDTH];
  assign _xor  = gates_d[slice_offset(GATE_XOR,  WIDTH) +: WIDTH];
  assign _xnor = gates_d[slice_offset(GATE_XNOR, WIDTH) +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gates_q <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      gates_q <= gates_d;
      valid_q <= 1'b1;
    end
  end

`ifdef ALL_GATES_REDUCE_EN
  logic [NUM_GATES-1:0] reduce_d;

  for (genvar k = 0; k < NUM_GATES; k++) begin : g_reduce
    assign reduce_d[k] = |gates_d[slice_offset(k, WIDTH) +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reduce_q <= '0;
    end else if (en) begin
      reduce_q <= reduce_d;
    end
  end
`endif

endmodule

// File: tb/tb_all_gates.sv
// Directed self-checking bench for all_gates at WIDTH=1 (truth table) and WIDTH=4 (registers).
module tb_all_gates;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       a1, b1;
  logic [3:0] a4, b4;

  logic       and1, or1, nand1, nor1, xor1, xnor1;
  logic [5:0] gates_q1;
  logic       valid_q1;

  logic [3:0]  and4, or4, nand4, nor4, xor4, xnor4;
  logic [23:0] gates_q4;
  logic        valid_q4;

`ifdef ALL_GATES_REDUCE_EN
  logic [5:0] reduce_q1;
  logic [5:0] reduce_q4;
`endif

  int passed;
  int total;

  all_gates #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a1),
    .b        (b1),
    .en       (en),
    ._and     (and1),
    ._or      (or1),
    ._nand    (nand1),
    ._nor     (nor1),
    ._xor     (xor1),
    ._xnor    (xnor1),
    .gates_q  (gates_q1),
    .valid_q  (valid_q1)
`ifdef ALL_GATES_REDUCE_EN
    ,
    .reduce_q (reduce_q1)
`endif
  );

  all_gates #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a4),
    .b        (b4),
    .en       (en),
    ._and     (and4),
    ._or      (or4),
    ._nand    (nand4),
    ._nor     (nor4),
    ._xor     (xor4),
    ._xnor    (xnor4),
    .gates_q  (gates_q4),
    .valid_q  (valid_q4)
`ifdef ALL_GATES_REDUCE_EN
    ,
    .reduce_q (reduce_q4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference packing {xnor,xor,nor,nand,or,and} for a 4-bit operand pair.
  function automatic logic [23:0] model4(input logic [3:0] a, input logic [3:0] b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  function automatic logic [5:0] reduce_model(input logic [23:0] g);
    logic [5:0] r;
    for (int k = 0; k < 6; k++) r[k] = |g[k*4 +: 4];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    a1 = 1'b1; b1 = 1'b1;
    a4 = 4'hF; b4 = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (gates_q4 !== 24'h0) $display("FAIL reset_gates_q4: got %h want %h", gates_q4, 24'h0);
    else passed++;
    total++;
    if (valid_q4 !== 1'b0) $display("FAIL reset_valid_q4: got %b want 0", valid_q4);
    else passed++;
    total++;
    if (gates_q1 !== 6'h0 || valid_q1 !== 1'b0)
      $display("FAIL reset_dut1_regs: got %h/%b want 00/0", gates_q1, valid_q1);
    else passed++;
    total++;
    if (and1 !== 1'b1 || xnor1 !== 1'b1)
      $display("FAIL reset_comb_dut1: got and=%b xnor=%b want 1/1", and1, xnor1);
    else passed++;
    total++;
    if (and4 !== 4'hF || nand4 !== 4'h0)
      $display("FAIL reset_comb_dut4: got and=%h nand=%h want F/0", and4, nand4);
    else passed++;
`ifdef ALL_GATES_REDUCE_EN
    total++;
    if (reduce_q4 !== 6'h0) $display("FAIL reset_reduce_q4: got %b want 000000", reduce_q4);
    else passed++;
`endif
  endtask

  task automatic test_truth_table();
    logic [3:0] and_tab, or_tab, nand_tab, nor_tab, xor_tab, xnor_tab;
    logic [5:0] exp;
    logic [5:0] got;
    logic [1:0] ab;
    and_tab  = 4'b1000;
    or_tab   = 4'b1110;
    nand_tab = 4'b0111;
    nor_tab  = 4'b0001;
    xor_tab  = 4'b0110;
    xnor_tab = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      #10;
      exp = {xnor_tab[i], xor_tab[i], nor_tab[i], nand_tab[i], or_tab[i], and_tab[i]};
      got = {xnor1, xor1, nor1, nand1, or1, and1};
      total++;
      if (got !== exp) $display("FAIL truth_ab%0d%0d: got %b want %b", ab[1], ab[0], got, exp);
      else passed++;
    end
    @(posedge clk);
    #1;
    total++;
    if (valid_q4 !== 1'b0 || gates_q4 !== 24'h0)
      $display("FAIL en_low_no_capture: got %h/%b want 000000/0", gates_q4, valid_q4);
    else passed++;
  endtask

  task automatic test_capture();
    @(negedge clk);
    a4 = 4'hC;
    b4 = 4'hA;
    en = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (gates_q4 !== 24'h9617E8) $display("FAIL capture_gates_q4: got %h want 9617e8", gates_q4);
    else passed++;
    total++;
    if (valid_q4 !== 1'b1) $display("FAIL capture_valid_q4: got %b want 1", valid_q4);
    else passed++;
    // a1=b1=1 from the last truth-table step
    total++;
    if (gates_q1 !== 6'b100011) $display("FAIL capture_gates_q1: got %b want 100011", gates_q1);
    else passed++;
`ifdef ALL_GATES_REDUCE_EN
    total++;
    if (reduce_q4 !== 6'b111111) $display("FAIL capture_reduce_q4: got %b want 111111", reduce_q4);
    else passed++;
`endif
  endtask

  task automatic test_hold();
    logic [23:0] got;
    @(negedge clk);
    en = 1'b0;
    a4 = 4'h0;
    b4 = 4'hF;
    #1;
    got = {xnor4, xor4, nor4, nand4, or4, and4};
    total++;
    if (got !== 24'h0F0FF0) $display("FAIL hold_comb_update: got %h want 0f0ff0", got);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (gates_q4 !== 24'h9617E8 || valid_q4 !== 1'b1)
      $display("FAIL hold_regs: got %h/%b want 9617e8/1", gates_q4, valid_q4);
    else passed++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (gates_q4 !== 24'h0 || valid_q4 !== 1'b0)
      $display("FAIL async_reset_regs: got %h/%b want 000000/0", gates_q4, valid_q4);
    else passed++;
`ifdef ALL_GATES_REDUCE_EN
    total++;
    if (reduce_q4 !== 6'h0) $display("FAIL async_reset_reduce: got %b want 000000", reduce_q4);
    else passed++;
`endif
    // Capture requested while reset is still low must not land.
    en = 1'b1;
    a4 = 4'h5;
    b4 = 4'h3;
    @(posedge clk);
    #1;
    total++;
    if (gates_q4 !== 24'h0 || valid_q4 !== 1'b0)
      $display("FAIL reset_beats_en: got %h/%b want 000000/0", gates_q4, valid_q4);
    else passed++;
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [23:0] exp_q;
    logic        exp_valid;
    exp_q     = 24'h0;
    exp_valid = 1'b0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      en = (n < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      total++;
      if (nand4 !== ~and4 || nor4 !== ~or4 || xnor4 !== ~xor4)
        $display("FAIL rand_invariant_%0d: got nand=%h and=%h nor=%h or=%h xnor=%h xor=%h",
                 n, nand4, and4, nor4, or4, xnor4, xor4);
      else passed++;
      total++;
      if ({xnor4, xor4, nor4, nand4, or4, and4} !== model4(a4, b4))
        $display("FAIL rand_comb_%0d: got %h want %h", n,
                 {xnor4, xor4, nor4, nand4, or4, and4}, model4(a4, b4));
      else passed++;
      @(posedge clk);
      if (en) begin
        exp_q     = model4(a4, b4);
        exp_valid = 1'b1;
      end
      #1;
      total++;
      if (gates_q4 !== exp_q || valid_q4 !== exp_valid)
        $display("FAIL rand_regs_%0d: got %h/%b want %h/%b", n, gates_q4, valid_q4,
                 exp_q, exp_valid);
      else passed++;
`ifdef ALL_GATES_REDUCE_EN
      total++;
      if (reduce_q4 !== reduce_model(exp_q))
        $display("FAIL rand_reduce_%0d: got %b want %b", n, reduce_q4, reduce_model(exp_q));
      else passed++;
`endif
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_truth_table();
    test_capture();
    test_hold();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
